// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue.
// Watches the program counter's change-toggle, issues one instruction-memory read per new PC
// value over a valid/ready request channel and buffers returned (pc, instruction) pairs in a
// Depth-entry FIFO toward decode. A taken jump (flush_i) empties the FIFO and squashes any
// fetch still in flight.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   pc_value_i               current PC address
//   pc_changed_times_i       PC toggle bit, flips on every PC update
//   pc_stall_o               holds the program counter
//   flush_i                  jump taken this cycle
//   mem_request_*            read request channel (valid/ready, address)
//   mem_response_*           read response (valid, instruction word)
//   out_valid_o/out_ready_i  head entry handshake toward decode
//   out_pc_o/out_instruction_o  head entry contents
//   count_o                  FIFO occupancy
module instruction_fetch_queue #(
   parameter int unsigned Depth = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [31:0]                  pc_value_i,
   input  logic                         pc_changed_times_i,
   output logic                         pc_stall_o,
   input  logic                         flush_i,
   output logic                         mem_request_valid_o,
   input  logic                         mem_request_ready_i,
   output logic [31:0]                  mem_request_address_o,
   input  logic                         mem_response_valid_i,
   input  logic [31:0]                  mem_response_data_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [31:0]                  out_pc_o,
   output logic [31:0]                  out_instruction_o,
   output logic [$clog2(Depth+1)-1:0]   count_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = $clog2(Depth + 1);
   localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

   typedef enum logic [1:0] {StIdle, StRequest, StWait} state_e;

   state_e            state_q, state_d;
   logic              last_toggle_q, last_toggle_d;
   logic              squash_q, squash_d;
   logic [31:0]       addr_q, addr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [31:0]       pc_mem_q    [Depth];
   logic [31:0]       instr_mem_q [Depth];

   logic new_pc, capture, resp_fire, push, pop;

   assign new_pc    = pc_changed_times_i != last_toggle_q;
   // The FIFO slot is reserved here: with only one fetch in flight, count < Depth at capture
   // guarantees room when the response returns.
   assign capture   = new_pc && (state_q == StIdle) && (count_q < DepthCnt) && !flush_i;
   assign resp_fire = (state_q == StWait) && mem_response_valid_i;
   assign push      = resp_fire && !squash_q && !flush_i;
   assign pop       = out_valid_o && out_ready_i;

   // Flush lets the PC load its jump target this edge.
   assign pc_stall_o = new_pc && !capture && !flush_i;

   // ---------------------------------------------------------------- FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------- FSM next state
   // Flush never aborts a request: valid stays up until accepted and the response is awaited.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (capture)              state_d = StRequest;
         StRequest: if (mem_request_ready_i)  state_d = StWait;
         StWait:    if (mem_response_valid_i) state_d = StIdle;
         default:                             state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------- FSM outputs
   always_comb begin
      mem_request_valid_o   = (state_q == StRequest);
      mem_request_address_o = addr_q;
   end

   // ---------------------------------------------------------------- control next state
   always_comb begin
      last_toggle_d = last_toggle_q;
      squash_d      = squash_q;
      addr_d        = addr_q;
      if (capture) begin
         addr_d        = pc_value_i;
         last_toggle_d = pc_changed_times_i;
      end
      if (resp_fire) begin
         squash_d = 1'b0;
      end
      if (flush_i) begin
         last_toggle_d = pc_changed_times_i;
         // A response landing in the flush cycle retires the wrong-path fetch by itself.
         if ((state_q == StRequest) || ((state_q == StWait) && !mem_response_valid_i)) begin
            squash_d = 1'b1;
         end
      end
   end

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (flush_i) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         last_toggle_q <= 1'b1;
         squash_q      <= 1'b0;
         addr_q        <= '0;
         count_q       <= '0;
      end else begin
         last_toggle_q <= last_toggle_d;
         squash_q      <= squash_d;
         addr_q        <= addr_d;
         count_q       <= count_d;
      end
   end

   // ---------------------------------------------------------------- FIFO storage
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int unsigned i = 0; i < Depth; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) begin
            pc_mem_q[wr_ptr_q]    <= addr_q;
            instr_mem_q[wr_ptr_q] <= mem_response_data_i;
            wr_ptr_q              <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   assign out_valid_o       = (count_q != '0) && !flush_i;
   assign out_pc_o          = pc_mem_q[rd_ptr_q];
   assign out_instruction_o = instr_mem_q[rd_ptr_q];
   assign count_o           = count_q;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: a PC model and a memory model run in the background,
// and every PC value the model presents is pushed to request and output scoreboards.
module tb_instruction_fetch_queue;

   localparam int unsigned Depth = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc_value = 32'h2FFC;
   logic        pc_toggle = 1'b1;
   logic        pc_stall;
   logic        flush = 1'b0;
   logic        mreq_valid;
   logic        mreq_ready = 1'b1;
   logic [31:0] mreq_addr;
   logic        mresp_valid = 1'b0;
   logic [31:0] mresp_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [2:0]  count;

   int n_cmp = 0;
   int n_fail = 0;

   logic [31:0] req_exp[$];
   logic [31:0] out_exp[$];

   bit          env_en = 1'b0;
   bit          pc_run = 1'b1;
   bit          flush_req = 1'b0;
   logic [31:0] flush_target = '0;
   int          resp_lat = 1;
   bit          resp_pend = 1'b0;
   int          resp_cnt = 0;
   logic [31:0] resp_addr = '0;
   int          n_acc = 0;
   int          n_pops = 0;
   logic [31:0] last_acc = '0;
   logic [31:0] last_pop_pc = '0;

   bit          e_act, e_acc, e_adv, e_fl, e_keep;
   logic [31:0] e_exp, e_h;

   instruction_fetch_queue #(.Depth(Depth)) dut (
      .clk_i                 (clk),
      .rst_ni                (rst_n),
      .pc_value_i            (pc_value),
      .pc_changed_times_i    (pc_toggle),
      .pc_stall_o            (pc_stall),
      .flush_i               (flush),
      .mem_request_valid_o   (mreq_valid),
      .mem_request_ready_i   (mreq_ready),
      .mem_request_address_o (mreq_addr),
      .mem_response_valid_i  (mresp_valid),
      .mem_response_data_i   (mresp_data),
      .out_valid_o           (out_valid),
      .out_ready_i           (out_ready),
      .out_pc_o              (out_pc),
      .out_instruction_o     (out_instr),
      .count_o               (count)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   // Environment: observe at the falling edge, apply PC/memory updates 1ns after the rising edge.
   initial begin
      forever begin
         @(negedge clk);
         e_act = env_en; e_acc = 0; e_adv = 0; e_fl = 0; e_keep = 0;
         if (e_act) begin
            if (mreq_valid && mreq_ready) begin
               e_acc = 1;
               n_cmp++;
               if (req_exp.size() == 0) begin
                  n_fail++;
                  $display("FAIL req_addr: got request %h, required no request", mreq_addr);
               end else begin
                  e_exp = req_exp.pop_front();
                  if (mreq_addr !== e_exp) begin
                     n_fail++;
                     $display("FAIL req_addr: got %h, required %h", mreq_addr, e_exp);
                  end
               end
               last_acc = mreq_addr;
               n_acc++;
            end
            if (out_valid && out_ready) begin
               n_cmp++;
               if (out_exp.size() == 0) begin
                  n_fail++;
                  $display("FAIL out_pop: got pc %h, required no output", out_pc);
               end else begin
                  e_exp = out_exp.pop_front();
                  if (out_pc !== e_exp || out_instr !== ~e_exp) begin
                     n_fail++;
                     $display("FAIL out_pair: got (%h,%h), required (%h,%h)",
                              out_pc, out_instr, e_exp, ~e_exp);
                  end
               end
               last_pop_pc = out_pc;
               n_pops++;
            end
            e_fl   = flush;
            e_keep = mreq_valid && !mreq_ready;
            e_adv  = pc_run && !pc_stall && !flush;
         end
         @(posedge clk);
         #1;
         if (e_act && env_en) begin
            mresp_valid = 1'b0;
            if (e_acc) begin
               resp_pend = 1'b1;
               resp_cnt  = resp_lat;
               resp_addr = last_acc;
            end
            if (resp_pend) begin
               if (resp_cnt <= 1) begin
                  mresp_valid = 1'b1;
                  mresp_data  = ~resp_addr;
                  resp_pend   = 1'b0;
               end else begin
                  resp_cnt--;
               end
            end
            if (e_fl) begin
               flush     = 1'b0;
               pc_value  = flush_target;
               pc_toggle = ~pc_toggle;
               // A request still waiting for ready will complete with its old address.
               if (e_keep && req_exp.size() > 0) begin
                  e_h = req_exp[0];
                  req_exp.delete();
                  req_exp.push_back(e_h);
               end else begin
                  req_exp.delete();
               end
               out_exp.delete();
               req_exp.push_back(flush_target);
               out_exp.push_back(flush_target);
            end else if (flush_req) begin
               flush     = 1'b1;
               flush_req = 1'b0;
            end else if (e_adv) begin
               pc_value  = pc_value + 32'd4;
               pc_toggle = ~pc_toggle;
               req_exp.push_back(pc_value);
               out_exp.push_back(pc_value);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      env_en      = 1'b0;
      rst_n       = 1'b0;
      flush       = 1'b0;
      flush_req   = 1'b0;
      mresp_valid = 1'b0;
      mresp_data  = '0;
      mreq_ready  = 1'b1;
      out_ready   = 1'b1;
      pc_value    = 32'h2FFC;
      pc_toggle   = 1'b1;
      pc_run      = 1'b1;
      resp_lat    = 1;
      resp_pend   = 1'b0;
      n_acc       = 0;
      req_exp.delete();
      out_exp.delete();
      repeat (3) step();
      rst_n  = 1'b1;
      env_en = 1'b1;
   endtask

   task automatic test_drain(input string tag);
      int k = 0;
      pc_run     = 1'b0;
      out_ready  = 1'b1;
      mreq_ready = 1'b1;
      while (k < 300 && !(req_exp.size() == 0 && out_exp.size() == 0 && count == 3'd0)) begin
         step();
         k++;
      end
      n_cmp++;
      if (req_exp.size() != 0 || out_exp.size() != 0) begin
         n_fail++;
         $display("FAIL drain_%s: %0d requests / %0d outputs outstanding, required 0/0",
                  tag, req_exp.size(), out_exp.size());
      end
      repeat (4) step();
      n_cmp++;
      if (mreq_valid !== 1'b0 || count !== 3'd0) begin
         n_fail++;
         $display("FAIL idle_%s: valid=%b count=%0d, required 0/0", tag, mreq_valid, count);
      end
   endtask

   task automatic test_reset();
      env_en = 1'b0;
      rst_n  = 1'b0;
      #3;
      n_cmp++;
      if (mreq_valid !== 1'b0 || out_valid !== 1'b0 || pc_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valids: req=%b out=%b stall=%b, required 0", mreq_valid,
                  out_valid, pc_stall);
      end
      n_cmp++;
      if (count !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_count: got %0d, required 0", count);
      end
      n_cmp++;
      if (out_pc !== 32'h0 || out_instr !== 32'h0 || mreq_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_data: pc=%h instr=%h addr=%h, required 0", out_pc, out_instr,
                  mreq_addr);
      end
      do_reset();
   endtask

   task automatic test_stream();
      int p0;
      do_reset();
      step();
      n_cmp++;
      if (mreq_valid !== 1'b0 || pc_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL first_cycle: req=%b stall=%b, required 0/0", mreq_valid, pc_stall);
      end
      step();
      n_cmp++;
      if (mreq_valid !== 1'b1 || mreq_addr !== 32'h3000 || pc_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL first_request: req=%b addr=%h stall=%b, required 1/00003000/1",
                  mreq_valid, mreq_addr, pc_stall);
      end
      repeat (10) step();
      p0 = n_pops;
      repeat (30) step();
      n_cmp++;
      if (n_pops - p0 != 10) begin
         n_fail++;
         $display("FAIL throughput: got %0d outputs in 30 cycles, required 10", n_pops - p0);
      end
      test_drain("stream");
   endtask

   task automatic test_full_stall();
      int k = 0;
      do_reset();
      out_ready = 1'b0;
      while (k < 60 && count != 3'd4) begin step(); k++; end
      n_cmp++;
      if (count !== 3'd4) begin
         n_fail++;
         $display("FAIL full_count: got %0d, required 4", count);
      end
      repeat (3) begin
         step();
         n_cmp++;
         if (pc_stall !== 1'b1 || mreq_valid !== 1'b0 || count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_hold: stall=%b req=%b count=%0d, required 1/0/4", pc_stall,
                     mreq_valid, count);
         end
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_cmp++;
      if (count !== 3'd3 || mreq_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL full_pop: count=%0d req=%b, required 3/0", count, mreq_valid);
      end
      step();
      n_cmp++;
      if (mreq_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL full_refetch: req=%b, required 1", mreq_valid);
      end
      k = 0;
      while (k < 20 && count != 3'd4) begin step(); k++; end
      n_cmp++;
      if (count !== 3'd4) begin
         n_fail++;
         $display("FAIL full_refill: got %0d, required 4", count);
      end
      test_drain("full");
   endtask

   task automatic test_flush_wait();
      int k = 0;
      int p0;
      do_reset();
      out_ready = 1'b0;
      resp_lat  = 3;
      while (k < 40 && n_acc < 3) begin step(); k++; end
      n_cmp++;
      if (n_acc != 3 || last_acc !== 32'h3008) begin
         n_fail++;
         $display("FAIL flushw_setup: accepts=%0d last=%h, required 3/00003008", n_acc,
                  last_acc);
      end
      flush_target = 32'h4000;
      flush_req    = 1'b1;
      step();
      n_cmp++;
      if (out_valid !== 1'b0 || pc_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL flushw_cycle: out=%b stall=%b, required 0/0", out_valid, pc_stall);
      end
      step();
      n_cmp++;
      if (count !== 3'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flushw_count: count=%0d out=%b, required 0/0", count, out_valid);
      end
      out_ready = 1'b1;
      p0 = n_pops;
      k  = 0;
      while (k < 40 && n_pops == p0) begin step(); k++; end
      n_cmp++;
      if (n_pops == p0 || last_pop_pc !== 32'h4000) begin
         n_fail++;
         $display("FAIL flushw_first: got %h, required 00004000", last_pop_pc);
      end
      test_drain("flushw");
   endtask

   task automatic test_flush_request();
      int k = 0;
      int p0;
      do_reset();
      mreq_ready = 1'b0;
      while (k < 10 && mreq_valid !== 1'b1) begin step(); k++; end
      flush_target = 32'h5000;
      flush_req    = 1'b1;
      repeat (4) begin
         step();
         n_cmp++;
         if (mreq_valid !== 1'b1 || mreq_addr !== 32'h3000) begin
            n_fail++;
            $display("FAIL flushr_hold: req=%b addr=%h, required 1/00003000", mreq_valid,
                     mreq_addr);
         end
      end
      p0 = n_pops;
      mreq_ready = 1'b1;
      k = 0;
      while (k < 40 && n_pops == p0) begin step(); k++; end
      n_cmp++;
      if (n_pops == p0 || last_pop_pc !== 32'h5000) begin
         n_fail++;
         $display("FAIL flushr_first: got %h, required 00005000", last_pop_pc);
      end
      test_drain("flushr");
   endtask

   task automatic test_back_to_back();
      int k = 0;
      do_reset();
      out_ready = 1'b0;
      while (k < 40 && count != 3'd3) begin step(); k++; end
      k = 0;
      while (k < 20 && mresp_valid !== 1'b1) begin step(); k++; end
      n_cmp++;
      if (count !== 3'd3 || mresp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_setup: count=%0d resp=%b, required 3/1", count, mresp_valid);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_cmp++;
      if (count !== 3'd3) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d, required 3", count);
      end
      test_drain("b2b");
   endtask

   task automatic test_async_reset();
      int k = 0;
      do_reset();
      out_ready = 1'b0;
      resp_lat  = 4;
      while (k < 40 && n_acc < 2) begin step(); k++; end
      n_cmp++;
      if (count !== 3'd1 || n_acc != 2) begin
         n_fail++;
         $display("FAIL arst_setup: count=%0d accepts=%0d, required 1/2", count, n_acc);
      end
      env_en    = 1'b0;
      rst_n     = 1'b0;
      pc_toggle = 1'b1;
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || mreq_valid !== 1'b0 || count !== 3'd0) begin
         n_fail++;
         $display("FAIL arst_immediate: out=%b req=%b count=%0d, required 0/0/0", out_valid,
                  mreq_valid, count);
      end
      step();
      mresp_valid = 1'b1;
      mresp_data  = 32'hDEADBEEF;
      step();
      rst_n = 1'b1;
      step();
      mresp_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b0 || mreq_valid !== 1'b0 || count !== 3'd0) begin
         n_fail++;
         $display("FAIL arst_late_resp: out=%b req=%b count=%0d, required 0/0/0", out_valid,
                  mreq_valid, count);
      end
      do_reset();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_full_stall();
      test_flush_wait();
      test_flush_request();
      test_back_to_back();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_queue.md
# instruction_fetch_queue

Fetch-side consumer of the program counter's address stream: detects each new PC value via its change-toggle bit, issues one instruction-memory read per address over a valid/ready request channel, and buffers returned (pc, instruction) pairs in a DEPTH-entry FIFO toward decode. It stalls the program counter whenever an address cannot be absorbed, and on a taken jump squashes all buffered and in-flight wrong-path fetches. Sits between the program counter and the decode stage.

## Interface

- DEPTH, 4, FIFO entries; power of two, ≥2
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- pcValue  in  32  current PC address
- pcChangedTimes  in  1  PC toggle bit; flips on every PC update
- pcStall  out  1  holds the program counter
- flush  in  1  jump taken this cycle; discard wrong-path work
- memRequestValid  out  1  read request valid
- memRequestReady  in  1  memory accepts request
- memRequestAddress  out  32  read address
- memResponseValid  in  1  read data valid
- memResponseData  in  32  instruction word
- outValid  out  1  head entry valid toward decode
- outReady  in  1  decode consumes head entry
- outPc  out  32  head entry address
- outInstruction  out  32  head entry instruction
- count  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation

- Registers: state {IDLE, REQUEST, WAIT}, lastToggle, squash, address register, FIFO storage, read/write pointers, count.
- newPc = pcChangedTimes != lastToggle. capture = newPc && state==IDLE && count<DEPTH && !flush.
- pcStall = newPc && !capture && !flush (combinational). Flush forces 0 so the PC loads its jump target that edge.
- IDLE: on capture, address ← pcValue, lastToggle ← pcChangedTimes, → REQUEST.
- REQUEST: memRequestValid=1, memRequestAddress=address register; on memRequestReady → WAIT. Valid never withdraws before ready, even under flush.
- WAIT: on memResponseValid, push {address, memResponseData} unless squash; clear squash; → IDLE. memResponseValid outside WAIT is ignored.
- Exactly one request outstanding. FIFO slot is reserved at capture (count<DEPTH checked only in IDLE; no slot can be lost since only one fetch is in flight).
- FIFO: outValid = count!=0 && !flush; pop on outValid && outReady. Push+pop same cycle: count unchanged. Push at count==DEPTH cannot occur.
- flush (highest priority): count ← 0, pointers ← 0, lastToggle ← pcChangedTimes; if state is REQUEST or WAIT, squash ← 1 (request completes, response dropped). No pop and no push-to-visible-queue in the flush cycle.
- Reset (async, active-low): state IDLE, count 0, pointers 0, squash 0, lastToggle 1 (matches PC reset toggle), address register and all entries 0. Outputs: memRequestValid 0, outValid 0, outPc 0, outInstruction 0, memRequestAddress 0, count 0, pcStall 0.

## Timing

- PC toggle visible in cycle c → captured at edge c+1; memRequestValid high from cycle c+1.
- Request accept edge → WAIT next cycle; response in cycle r → entry visible (outValid, count) from r+1.
- Zero-wait memory (ready always, response the cycle after accept): one instruction per 3 cycles; PC advances on the capture edge, next address stalls until IDLE.
- After flush at edge f: PC holds target from f; target captured at earliest edge f+1 if IDLE, else after squashed response retires.
- Async reset mid-operation: all state cleared without a clock edge; a response arriving afterward is ignored (state IDLE).

## Test plan

- Reset release, memRequestReady=1, response one cycle after accept with data=~address, outReady=1 → requests 0x3000, 0x3004, 0x3008 in order; outputs pairs (0x3000, 0xFFFFCFFF) etc.; no address skipped or duplicated.
- outReady=0, DEPTH=4 → count reaches 4, pcStall held, no fifth request; one pop → next request issued, count returns to 4.
- flush while WAIT for 0x3008 with target 0x4000 → count 0 immediately, 0x3008 response discarded, next request address 0x4000, first output 0x4000.
- flush during REQUEST with memRequestReady=0 for 3 cycles → memRequestValid stays high with same address until accepted, response dropped, then fetch of target.
- Async reset asserted in WAIT, no clock edge → outValid, memRequestValid, count 0 at once; later memResponseValid pulse writes nothing.
- count=3, response and pop same cycle → count stays 3, FIFO order preserved.
